// File: rtl/inst_fetch_pkg.sv
// Shared constants and types for the instruction fetch unit and its cache.
// Opcodes are shared with the decoder.
package inst_fetch_pkg;

    localparam int unsigned ICACHE_INDEX_BITS_DEFAULT = 6;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        StRun       = 2'd0,
        StMiss      = 2'd1,
        StWaitRedir = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-unit bus: decoder handoff, redirect strobes and the refill port.
// master is the fetch unit; slave is the decoder/ROB/memory side.
interface inst_fetch_if;

    logic        need_inst;
    logic        inst_ready;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        clear_inst;
    logic [31:0] if_addr;
    logic        rob_clear;
    logic [31:0] rob_jump_addr;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    modport master (
        input  need_inst,
        input  clear_inst,
        input  if_addr,
        input  rob_clear,
        input  rob_jump_addr,
        input  mem_resp_valid,
        input  mem_resp_data,
        output inst_ready,
        output pc_out,
        output inst_out,
        output mem_req_valid,
        output mem_req_addr
    );

    modport slave (
        output need_inst,
        output clear_inst,
        output if_addr,
        output rob_clear,
        output rob_jump_addr,
        output mem_resp_valid,
        output mem_resp_data,
        input  inst_ready,
        input  pc_out,
        input  inst_out,
        input  mem_req_valid,
        input  mem_req_addr
    );

endinterface

// File: rtl/inst_fetch_icache.sv
// Direct-mapped instruction cache, one 32-bit word per line.
// Combinational lookup, single write port, valid bits cleared by reset.
module inst_fetch_icache
    import inst_fetch_pkg::*;
#(
    parameter int unsigned ICACHE_INDEX_BITS = ICACHE_INDEX_BITS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:2] i_rd_addr,
    output logic        o_hit,
    output logic [31:0] o_rd_data,
    input  logic        i_we,
    input  logic [31:2] i_wr_addr,
    input  logic [31:0] i_wr_data
);

    localparam int unsigned LINES    = 1 << ICACHE_INDEX_BITS;
    localparam int unsigned TAG_BITS = 30 - ICACHE_INDEX_BITS;

    logic [31:0]                  r_data [LINES];
    logic [TAG_BITS-1:0]          r_tag  [LINES];
    logic [LINES-1:0]             r_valid;
    logic [ICACHE_INDEX_BITS-1:0] w_rd_idx;
    logic [ICACHE_INDEX_BITS-1:0] w_wr_idx;

    assign w_rd_idx = i_rd_addr[ICACHE_INDEX_BITS+1:2];
    assign w_wr_idx = i_wr_addr[ICACHE_INDEX_BITS+1:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[w_wr_idx] <= 1'b1;
        end
    end

    // Data and tag storage needs no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_data[w_wr_idx] <= i_wr_data;
            r_tag[w_wr_idx]  <= i_wr_addr[31:ICACHE_INDEX_BITS+2];
        end
    end

    assign o_hit     = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == i_rd_addr[31:ICACHE_INDEX_BITS+2]);
    assign o_rd_data = r_data[w_rd_idx];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: holds the fetch PC, presents one instruction per cycle from the
// icache, refills misses and stalls after control flow until redirected.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int unsigned ICACHE_INDEX_BITS = ICACHE_INDEX_BITS_DEFAULT,
    parameter logic [31:0] RESET_PC          = 32'h0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    inst_fetch_if.master bus
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;
    logic [31:0]  r_fetch_addr;
    logic [31:0]  w_fetch_addr_next;
    logic         r_jalr_wait;
    logic         w_jalr_wait_next;

    logic         w_hit;
    logic [31:0]  w_line;
    logic [6:0]   w_opcode;
    logic         w_consume;
    logic         w_refill_we;
    logic         w_redirect;
    logic [31:0]  w_redirect_pc;

    inst_fetch_icache #(
        .ICACHE_INDEX_BITS(ICACHE_INDEX_BITS)
    ) u_icache (
        .clk       (clk),
        .rst       (rst),
        .i_rd_addr (r_pc[31:2]),
        .o_hit     (w_hit),
        .o_rd_data (w_line),
        .i_we      (w_refill_we),
        .i_wr_addr (r_fetch_addr[31:2]),
        .i_wr_data (bus.mem_resp_data)
    );

    assign w_opcode       = w_line[6:0];
    assign bus.inst_ready = rdy && (r_state == StRun) && w_hit;
    assign bus.pc_out     = r_pc;
    assign bus.inst_out   = w_hit ? w_line : 32'h0;
    assign bus.mem_req_valid = (r_state == StMiss);
    assign bus.mem_req_addr  = r_fetch_addr;

    assign w_consume   = bus.inst_ready && !bus.need_inst;
    assign w_refill_we = rdy && (r_state == StMiss) && bus.mem_resp_valid;

    // ROB flush outranks the decoder; a pending jalr only listens to the ROB.
    always_comb begin
        w_redirect    = 1'b0;
        w_redirect_pc = r_pc;
        if (bus.rob_clear) begin
            w_redirect    = 1'b1;
            w_redirect_pc = align_word(bus.rob_jump_addr);
        end else if (bus.clear_inst && !((r_state == StWaitRedir) && r_jalr_wait)) begin
            w_redirect    = 1'b1;
            w_redirect_pc = align_word(bus.if_addr);
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_fetch_addr_next = r_fetch_addr;
        w_jalr_wait_next  = r_jalr_wait;

        unique case (r_state)
            StRun: begin
                if (!w_hit) begin
                    w_fetch_addr_next = r_pc;
                    w_state_next      = StMiss;
                end else if (w_consume) begin
                    if (w_opcode == OPC_JAL || w_opcode == OPC_BRANCH) begin
                        w_state_next     = StWaitRedir;
                        w_jalr_wait_next = 1'b0;
                    end else if (w_opcode == OPC_JALR) begin
                        w_state_next     = StWaitRedir;
                        w_jalr_wait_next = 1'b1;
                    end else begin
                        w_pc_next = r_pc + 32'd4;
                    end
                end
            end
            StMiss: begin
                if (bus.mem_resp_valid) begin
                    w_state_next = StRun;
                end
            end
            StWaitRedir: begin
            end
            default: begin
                w_state_next = StRun;
            end
        endcase

        // An outstanding refill always completes, so a redirect in MISS only moves the PC.
        if (w_redirect) begin
            w_pc_next = w_redirect_pc;
            if (r_state != StMiss) begin
                w_state_next      = StRun;
                w_fetch_addr_next = r_fetch_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StRun;
            r_pc         <= RESET_PC;
            r_fetch_addr <= 32'h0;
            r_jalr_wait  <= 1'b0;
        end else if (rdy) begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_fetch_addr <= w_fetch_addr_next;
            r_jalr_wait  <= w_jalr_wait_next;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus randomized traffic, all checked
// every cycle against an address-level model of the PC, stall state and cache contents.
module tb_inst_fetch;

    logic clk = 1'b0;
    logic rst;
    logic rdy;

    inst_fetch_if bus ();

    inst_fetch #(
        .ICACHE_INDEX_BITS (6),
        .RESET_PC          (32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus for the next cycle; strobes are one-shot.
    logic        s_need;
    logic        s_clear;
    logic [31:0] s_if_addr;
    logic        s_rob;
    logic [31:0] s_rob_addr;

    // Memory responder.
    logic [31:0] mem [logic [31:0]];
    bit          ctrl_on;
    bit          rsp_busy;
    bit          rsp_drove;
    logic [31:0] rsp_addr;
    int          rsp_wait;
    int          rsp_lat;

    // Observed outputs of the current cycle.
    logic [31:0] o_ready;
    logic [31:0] o_pc;
    logic [31:0] o_inst;
    logic [31:0] o_req;
    logic [31:0] o_req_addr;

    // Reference model: mode 0 fetching, 1 refill outstanding, 2 stalled after control flow.
    int          m_mode;
    bit          m_rob_only;
    logic [31:0] m_pc;
    logic [31:0] m_fetch;
    logic [31:0] m_line_addr [64];
    bit          m_line_ok   [64];
    bit          exp_hit;

    logic [31:0] p_hold;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        int sel;
        if (mem.exists(a)) return mem[a];
        w = $urandom;
        w[6:0] = 7'b0010011;
        if (ctrl_on) begin
            sel = $urandom_range(0, 11);
            if (sel == 0) w[6:0] = 7'b1101111;
            else if (sel == 1) w[6:0] = 7'b1100011;
            else if (sel == 2) w[6:0] = 7'b1100111;
        end
        mem[a] = w;
        return w;
    endfunction

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 2) & 32'd63);
    endfunction

    function automatic logic [31:0] rand_target();
        if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        return 32'($urandom_range(0, 1023));
    endfunction

    task automatic model_reset();
        m_mode     = 0;
        m_rob_only = 1'b0;
        m_pc       = 32'h0;
        m_fetch    = 32'h0;
        for (int i = 0; i < 64; i++) begin
            m_line_ok[i]   = 1'b0;
            m_line_addr[i] = 32'h0;
        end
    endtask

    task automatic model_check();
        logic [31:0] exp_ready;
        int li;
        li = line_of(m_pc);
        exp_hit   = m_line_ok[li] && (m_line_addr[li] == m_pc);
        exp_ready = {31'b0, (rdy && m_mode == 0 && exp_hit)};
        check_val("inst_ready", o_ready, exp_ready);
        if (exp_ready[0]) begin
            check_val("pc_out", o_pc, m_pc);
            check_val("inst_out", o_inst, mem_word(m_pc));
        end
        check_val("mem_req_valid", o_req, {31'b0, (m_mode == 1)});
        if (m_mode == 1) check_val("mem_req_addr", o_req_addr, m_fetch);
    endtask

    task automatic model_advance();
        logic [31:0] w;
        int old_mode;
        bit redir;
        if (!rdy) return;
        old_mode = m_mode;
        redir    = 1'b0;
        if (m_mode == 0) begin
            if (!exp_hit) begin
                m_fetch = m_pc;
                m_mode  = 1;
            end else if (!s_need) begin
                w = mem_word(m_pc);
                if (w[6:0] == 7'b1101111 || w[6:0] == 7'b1100011) begin
                    m_mode     = 2;
                    m_rob_only = 1'b0;
                end else if (w[6:0] == 7'b1100111) begin
                    m_mode     = 2;
                    m_rob_only = 1'b1;
                end else begin
                    m_pc = m_pc + 32'd4;
                end
            end
        end else if (m_mode == 1) begin
            if (rsp_drove) begin
                m_line_addr[line_of(m_fetch)] = m_fetch;
                m_line_ok[line_of(m_fetch)]   = 1'b1;
                m_mode = 0;
            end
        end
        if (s_rob) begin
            m_pc  = s_rob_addr & 32'hFFFF_FFFC;
            redir = 1'b1;
        end else if (s_clear && !(old_mode == 2 && m_rob_only)) begin
            m_pc  = s_if_addr & 32'hFFFF_FFFC;
            redir = 1'b1;
        end
        if (redir && old_mode != 1) m_mode = 0;
    endtask

    // One clock cycle: drive, sample, check, respond, advance model, step to next negedge.
    task automatic cycle();
        rsp_drove = 1'b0;
        if (rsp_busy && rsp_wait == 0) rsp_drove = 1'b1;
        else if (rsp_busy) rsp_wait--;
        bus.need_inst      = s_need;
        bus.clear_inst     = s_clear;
        bus.if_addr        = s_if_addr;
        bus.rob_clear      = s_rob;
        bus.rob_jump_addr  = s_rob_addr;
        bus.mem_resp_valid = rsp_drove;
        bus.mem_resp_data  = rsp_drove ? mem_word(rsp_addr) : $urandom;
        #1;
        o_ready    = {31'b0, bus.inst_ready};
        o_pc       = bus.pc_out;
        o_inst     = bus.inst_out;
        o_req      = {31'b0, bus.mem_req_valid};
        o_req_addr = bus.mem_req_addr;
        model_check();
        if (rsp_drove && rdy) begin
            rsp_busy = 1'b0;
        end else if (!rsp_busy && o_req[0]) begin
            rsp_busy = 1'b1;
            rsp_addr = o_req_addr;
            rsp_wait = (rsp_lat < 0) ? int'($urandom_range(0, 3)) : rsp_lat;
        end
        model_advance();
        s_clear = 1'b0;
        s_rob   = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_ready(input string tag, input logic [31:0] pc, input int max_cycles);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!(o_ready[0] && o_pc == pc) && n < max_cycles);
        check_val(tag, o_pc, pc);
        check_val({tag, "_ready"}, o_ready, 32'd1);
    endtask

    task automatic redirect_dec(input logic [31:0] a);
        s_clear   = 1'b1;
        s_if_addr = a;
        cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        rdy = 1'b1;
        s_need = 1'b1; s_clear = 1'b0; s_if_addr = 32'h0; s_rob = 1'b0; s_rob_addr = 32'h0;
        bus.need_inst = 1'b1; bus.clear_inst = 1'b0; bus.if_addr = 32'h0;
        bus.rob_clear = 1'b0; bus.rob_jump_addr = 32'h0;
        bus.mem_resp_valid = 1'b0; bus.mem_resp_data = 32'h0;
        rsp_busy = 1'b0; rsp_drove = 1'b0; rsp_addr = 32'h0; rsp_wait = 0; rsp_lat = 3;
        ctrl_on = 1'b0;
        mem[32'h0000_0000] = 32'h0010_0093;
        mem[32'h0000_0010] = 32'h0000_0463;
        mem[32'h0000_0014] = 32'h0000_8067;
        model_reset();

        #1 rst = 1'b1;
        @(negedge clk);
        check_val("rst_inst_ready", {31'b0, bus.inst_ready}, 32'd0);
        check_val("rst_pc_out", bus.pc_out, 32'h0);
        check_val("rst_inst_out", bus.inst_out, 32'h0);
        check_val("rst_req_valid", {31'b0, bus.mem_req_valid}, 32'd0);
        check_val("rst_req_addr", bus.mem_req_addr, 32'h0);
        rst = 1'b0;

        // Cold start: request for 0x0 held while memory is slow.
        cycle();
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_val("cold_req_valid", o_req, 32'd1);
            check_val("cold_req_addr", o_req_addr, 32'h0);
        end
        wait_ready("cold_fill", 32'h0, 20);
        check_val("cold_inst", o_inst, 32'h0010_0093);
        rsp_lat = 0;

        // Warm 0x0-0xC, then stream back-to-back hits.
        s_need = 1'b0;
        wait_ready("warm_c", 32'hC, 40);
        redirect_dec(32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_val("stream_pc", o_pc, 32'(i * 4));
            check_val("stream_ready", o_ready, 32'd1);
            check_val("stream_noreq", o_req, 32'd0);
        end

        // Branch stalls until a decoder redirect.
        wait_ready("branch", 32'h10, 40);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_val("branch_stall", o_ready, 32'd0);
        end
        redirect_dec(32'h40);
        cycle();
        check_val("redir_pc", o_pc, 32'h40);

        // Jalr ignores the decoder and resumes only on a ROB flush.
        redirect_dec(32'h14);
        wait_ready("jalr", 32'h14, 40);
        redirect_dec(32'h80);
        cycle();
        check_val("jalr_ignore_ready", o_ready, 32'd0);
        check_val("jalr_ignore_pc", o_pc, 32'h14);
        s_rob = 1'b1; s_rob_addr = 32'h0; s_need = 1'b1;
        cycle();
        cycle();
        check_val("rob_resume_ready", o_ready, 32'd1);
        check_val("rob_resume_pc", o_pc, 32'h0);

        // ROB flush during a refill: the refill still lands, then the new target is fetched.
        rsp_lat = 3;
        redirect_dec(32'h20);
        cycle();
        cycle();
        check_val("miss20_req", o_req, 32'd1);
        check_val("miss20_addr", o_req_addr, 32'h20);
        s_rob = 1'b1; s_rob_addr = 32'h200;
        cycle();
        cycle();
        check_val("miss20_hold", o_req_addr, 32'h20);
        for (int i = 0; i < 20 && !(o_req[0] && o_req_addr == 32'h200); i++) cycle();
        check_val("req200_addr", o_req_addr, 32'h200);
        wait_ready("fill200", 32'h200, 20);
        redirect_dec(32'h20);
        cycle();
        check_val("hit20_ready", o_ready, 32'd1);
        check_val("hit20_pc", o_pc, 32'h20);
        check_val("hit20_noreq", o_req, 32'd0);
        rsp_lat = 0;

        // Aliasing on line 0: 0x200, 0x0 and 0x100 evict each other.
        redirect_dec(32'h0);
        cycle();
        check_val("alias0_miss", o_ready, 32'd0);
        cycle();
        check_val("alias0_req", o_req_addr, 32'h0);
        wait_ready("alias0_fill", 32'h0, 20);
        redirect_dec(32'h100);
        cycle();
        cycle();
        check_val("alias100_req", o_req_addr, 32'h100);
        wait_ready("alias100_fill", 32'h100, 20);
        redirect_dec(32'h0);
        cycle();
        cycle();
        check_val("aliasback_valid", o_req, 32'd1);
        check_val("aliasback_addr", o_req_addr, 32'h0);
        wait_ready("aliasback_fill", 32'h0, 20);

        // ROB flush outranks a simultaneous decoder redirect.
        s_rob = 1'b1; s_rob_addr = 32'h300; s_clear = 1'b1; s_if_addr = 32'h80;
        cycle();
        cycle();
        check_val("rob_wins_pc", o_pc, 32'h300);
        wait_ready("fill300", 32'h300, 20);

        // rdy low freezes the unit mid-stream.
        s_need = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        p_hold = m_pc;
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check_val("frozen_ready", o_ready, 32'd0);
            check_val("frozen_pc", o_pc, p_hold);
        end
        rdy = 1'b1;
        cycle();
        check_val("resume_pc", o_pc, p_hold);

        // Unaligned target is word-aligned, and pc+4 wraps to zero.
        s_rob = 1'b1; s_rob_addr = 32'hFFFF_FFFE;
        cycle();
        cycle();
        check_val("align_pc", o_pc, 32'hFFFF_FFFC);
        wait_ready("wrap_pc", 32'h0, 30);

        // Randomized traffic with control flow, stalls, redirects and rdy gaps.
        ctrl_on = 1'b1;
        rsp_lat = -1;
        for (int i = 0; i < 4000; i++) begin
            rdy        = ($urandom_range(0, 9) != 0);
            s_need     = ($urandom_range(0, 3) == 0);
            s_clear    = ($urandom_range(0, 29) == 0);
            s_if_addr  = rand_target();
            s_rob      = ($urandom_range(0, 49) == 0);
            s_rob_addr = rand_target();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit with a direct-mapped, one-word-per-line instruction cache. It sits between the memory controller and the decoder. It holds the architectural fetch PC, presents one instruction per cycle to the decoder, and refills misses from memory. It stalls after handing off control-flow instructions until it receives a redirect from the decoder (`clear_inst`/`if_addr`) or from the ROB (`rob_clear`).

## Interface
- `ICACHE_INDEX_BITS`, 6: number of cache index bits; the cache has 64 lines of one 32-bit word each.
- `RESET_PC`, 32'h0: PC loaded on reset.

- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `rdy` in 1: global enable; low freezes the block.
- `need_inst` in 1: decoder stall. Low while `inst_ready` is high means the instruction is consumed this cycle.
- `inst_ready` out 1: `pc_out`/`inst_out` are valid.
- `pc_out` out 32: PC of the presented instruction.
- `inst_out` out 32: instruction word.
- `clear_inst` in 1: decoder redirect strobe.
- `if_addr` in 32: decoder redirect target.
- `rob_clear` in 1: ROB flush strobe.
- `rob_jump_addr` in 32: ROB flush target.
- `mem_req_valid` out 1: refill request.
- `mem_req_addr` out 32: refill word address, low 2 bits zero.
- `mem_resp_valid` in 1: refill data valid, one-cycle pulse.
- `mem_resp_data` in 32: refill word.

## Operation
- Address split: offset [1:0], index [ICACHE_INDEX_BITS+1:2], tag [31:ICACHE_INDEX_BITS+2] (24 bits at default).
- State machine: RUN, MISS, WAIT_REDIR.
- RUN:
  - Hit (line valid and tag equal for `pc`): `inst_ready`=1, `inst_out`=line data, `pc_out`=`pc`.
  - Consume (`inst_ready` && !`need_inst`):
    - Opcode 1101111 (jal) or 1100011 (branch) → WAIT_REDIR, waiting for decoder or ROB.
    - Opcode 1100111 (jalr) → WAIT_REDIR, ROB redirect only.
    - Otherwise `pc` <= `pc`+4.
  - Miss: `fetch_addr` <= `pc`, go to MISS.
- MISS:
  - `mem_req_valid`=1, `mem_req_addr`=`fetch_addr`, held constant until `mem_resp_valid`.
  - On response: write data, tag and valid to line index(`fetch_addr`), go to RUN. Never WAIT_REDIR.
- WAIT_REDIR: `inst_ready`=0; no memory request.
- Redirects, applied in any state:
  - `rob_clear` → `pc` <= `rob_jump_addr`.
  - Else `clear_inst` (ignored while waiting on a jalr) → `pc` <= `if_addr`.
  - From RUN or WAIT_REDIR: next state RUN.
  - From MISS: `pc` updates but the state stays MISS; the outstanding refill completes and is written (it is a valid line), then RUN looks up the new `pc`.
  - `rob_clear` wins over `clear_inst` when both occur in the same cycle.
  - Any redirect in the same cycle as a consume overrides the +4 and the WAIT_REDIR transition.
- Redirect targets have bits [1:0] forced to 0.
- `rdy` low:
  - No register or array updates; a `mem_resp_valid` arriving then is lost and the memory controller must hold it.
  - `inst_ready` forced 0; `mem_req_valid` keeps its value.
- Arithmetic: `pc`+4 wraps mod 2^32 (0xFFFFFFFC → 0x0).

## Timing
- Reset values:
  - `pc`=RESET_PC, state RUN, all valid bits 0.
  - `inst_ready`=0, `pc_out`=RESET_PC, `inst_out`=0.
  - `mem_req_valid`=0, `mem_req_addr`=0.
- Hit: `inst_ready` is combinational from the registered `pc` and the arrays, so the instruction is presented in the same cycle `pc` changes. Throughput is one instruction per cycle with back-to-back hits.
- Miss latency:
  - 1 cycle RUN→MISS.
  - Then memory latency N.
  - Then 1 cycle RUN hit.
  - Total: instruction presented N+2 cycles after `pc` lands on a missing line.
- A redirect registered at edge k is presented at edge k+1 if it hits.
- `inst_out`/`pc_out` are stable while `inst_ready` is high and the instruction is not consumed.

## Structure
- `const.v` additions:
  - `icache_index_bits` define.
  - opcode defines for jal/jalr/branch, shared with the decoder.
  - fetch state encodings.
- One sub-module, `icache`:
  - data, tag and valid arrays.
  - combinational lookup port (hit/data).
  - one write port.
  - asynchronous clear of valid bits.
- `inst_fetch` keeps the FSM, `pc`, `fetch_addr` and redirect priority.

## Test plan
- Reset with RESET_PC=0, cold cache → `mem_req_valid`=1, `mem_req_addr`=0 held over 3 idle cycles. Response 0x00100093 → next cycle `inst_ready`=1, `pc_out`=0, `inst_out`=0x00100093.
- Lines 0x0–0x8 warm, `need_inst`=0 every cycle → `pc_out` 0, 4, 8 on consecutive cycles, no memory requests.
- Branch 0x00000463 at 0x10 consumed → `inst_ready`=0 for 5 cycles. `clear_inst` with `if_addr`=0x40 → next cycle `pc_out`=0x40. Jalr at 0x14 ignores `clear_inst` and resumes only on `rob_clear`.
- Miss on 0x20 with `rob_clear`, `rob_jump_addr`=0x200 during the wait → response for 0x20 is still filled, then a request for 0x200. A later redirect to 0x20 hits with no request.
- Aliasing: fill 0x0, then fetch 0x100 (same index) → miss, line replaced. Return to 0x0 → miss again.
- Simultaneous `rob_clear` (0x300) and `clear_inst` (0x80) → `pc_out`=0x300. `rdy`=0 for 4 cycles mid-stream → `inst_ready`=0, `pc` unchanged, resumes at the same `pc`.
